// File: rtl/samuelm_pwm_pkg.sv
// Shared constants and pin-level config payload for the 12-bit PWM generator.
package samuelm_pwm_pkg;

   localparam int unsigned PWM_W = 12;

   localparam logic SEL_DUTY   = 1'b0;
   localparam logic SEL_PERIOD = 1'b1;

   localparam logic [PWM_W-1:0] DUTY_RST   = 12'h000;
   localparam logic [PWM_W-1:0] PERIOD_RST = 12'hFFF;

   // Config write as seen on {uio_in, ui_in}.
   typedef struct packed {
      logic             wr_en;
      logic             sel;
      logic [1:0]       rsvd;
      logic [PWM_W-1:0] data;
   } cfg_bus_t;

   function automatic cfg_bus_t unpack_pins(input logic [7:0] ui, input logic [7:0] uio);
      cfg_bus_t c;
      c.wr_en = uio[7];
      c.sel   = uio[6];
      c.rsvd  = uio[5:4];
      c.data  = {uio[3:0], ui};
      return c;
   endfunction

endpackage

// File: rtl/samuelm_pwm_core.sv
// Free-running counter compared against duty/period; registered PWM output.
module samuelm_pwm_core
   import samuelm_pwm_pkg::*;
#(
   parameter int unsigned W = PWM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] duty_i,
   input  logic [W-1:0] period_i,
   output logic         pwm_o
);

   logic [W-1:0] counter_q, counter_d;
   logic         pwm_q, pwm_d;

   // Wrap uses whatever period is live this edge, so lowering it below the count wraps immediately.
   always_comb begin
      counter_d = counter_q + W'(1);
      if (counter_q >= period_i) begin
         counter_d = '0;
      end
      pwm_d = (counter_q < duty_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/samuelm_pwm_generator.sv
// Tiny Tapeout wrapper: pin unpacking, duty/period config registers and PWM core.
module samuelm_pwm_generator
   import samuelm_pwm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned WIDTH = PWM_W;

   cfg_bus_t         cfg;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             pwm;
   logic             unused_inputs;

   assign cfg           = unpack_pins(ui_in, uio_in);
   assign unused_inputs = ^{ena, cfg.rsvd};

   always_comb begin
      duty_d   = duty_q;
      period_d = period_q;
      if (cfg.wr_en) begin
         if (cfg.sel == SEL_DUTY) begin
            duty_d = cfg.data;
         end else begin
            period_d = cfg.data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q   <= DUTY_RST;
         period_q <= PERIOD_RST;
      end else begin
         duty_q   <= duty_d;
         period_q <= period_d;
      end
   end

   samuelm_pwm_core #(
      .W (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .duty_i   (duty_q),
      .period_i (period_q),
      .pwm_o    (pwm)
   );

   // All uio pins are inputs; only uo_out[0] carries a signal.
   assign uo_out  = {7'b0, pwm};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_samuelm_pwm_generator.sv
// Scoreboard bench: stimulus queues per-cycle expected PWM levels, a negedge monitor compares.
module tb_samuelm_pwm_generator;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   samuelm_pwm_generator dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic pwm;
      int   tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic string tag_name(input int t);
      case (t)
         0:       return "reset";
         1:       return "basic";
         2:       return "fullwidth";
         3:       return "duty0";
         4:       return "duty_gt_period";
         5:       return "period0";
         6:       return "live_update";
         7:       return "reset_mid";
         default: return "unknown";
      endcase
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push(input int tag, input logic v);
      exp_t e;
      e.pwm = v;
      e.tag = tag;
      sb_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({tag_name(e.tag), "_pwm"}, 32'(uo_out[0]), 32'(e.pwm));
         check({tag_name(e.tag), "_tie"}, 32'({uo_out[7:1], uio_out, uio_oe}), 32'd0);
      end
   end

   // Called at a posedge; drives one write that lands on the next posedge, with junk on unused pins.
   task automatic wr(input logic sel, input logic [11:0] d);
      #1;
      ui_in  = d[7:0];
      uio_in = {1'b1, sel, 2'($urandom), d[11:8]};
      ena    = 1'($urandom);
      @(posedge clk);
   endtask

   task automatic wr_release();
      #1;
      ui_in  = 8'($urandom);
      uio_in = {1'b0, 7'($urandom)};
      ena    = 1'($urandom);
   endtask

   // period=0 then period=P parks the counter at 0; the duty write after it fixes the phase.
   task automatic configure(input logic [11:0] d, input logic [11:0] p);
      wr(1'b1, 12'h000);
      wr(1'b1, p);
      wr(1'b0, d);
      wr_release();
   endtask

   // k-th edge after configure: counter before that edge is k mod (P+1).
   task automatic run_pattern(input int tag, input logic [11:0] d, input logic [11:0] p, input int n);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         push(tag, (k % (int'(p) + 1)) < int'(d));
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      repeat (5) begin
         @(posedge clk);
         push(0, 1'b0);
      end
      #1 rst_n = 1'b1;
      repeat (8192) begin
         @(posedge clk);
         push(0, 1'b0);
      end

      configure(12'd3, 12'd9);
      run_pattern(1, 12'd3, 12'd9, 200);

      configure(12'h123, 12'hABC);
      run_pattern(2, 12'h123, 12'hABC, 2 * 12'hABD);

      configure(12'd0, 12'd9);
      run_pattern(3, 12'd0, 12'd9, 40);
      configure(12'd10, 12'd9);
      run_pattern(4, 12'd10, 12'd9, 40);
      configure(12'd1, 12'd0);
      run_pattern(5, 12'd1, 12'd0, 40);

      // Counter at 80 when period drops 99 -> 20: old period this edge (80->81), wrap next edge.
      configure(12'd10, 12'd99);
      run_pattern(6, 12'd10, 12'd99, 79);
      wr(1'b1, 12'd20);
      push(6, 1'b0);
      wr_release();
      @(posedge clk);
      push(6, 1'b0);
      for (int j = 1; j <= 63; j++) begin
         @(posedge clk);
         push(6, ((j - 1) % 21) < 10);
      end

      configure(12'd5, 12'd9);
      run_pattern(7, 12'd5, 12'd9, 1);
      @(posedge clk);
      #2;
      check("reset_mid_pre", 32'(uo_out[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_async", 32'(uo_out[0]), 32'd0);
      repeat (3) begin
         @(posedge clk);
         push(7, 1'b0);
      end
      #3 rst_n = 1'b1;
      repeat (300) begin
         @(posedge clk);
         push(7, 1'b0);
      end

      repeat (2) @(negedge clk);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/samuelm_pwm_generator.md
Name: samuelm_pwm_generator

Overview:
- Configurable 12-bit PWM generator wrapped in the standard Tiny Tapeout user-project pin interface.
- Two 12-bit registers, duty and period, are written through the dedicated and bidirectional input pins.
- A free-running counter is compared against them to drive a single PWM output on uo_out[0].

Parameters:
- WIDTH, 12, counter/register width. Fixed by the pin map; not to be overridden at top level.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  design-selected strobe; ignored by logic.
- ui_in  in  8  data[7:0].
- uio_in  in  8  [3:0] = data[11:8]; [5:4] unused; [6] = sel; [7] = wr_en.
- uo_out  out  8  [0] = pwm_out; [7:1] tied 0.
- uio_out  out  8  tied 0.
- uio_oe  out  8  tied 0 (all uio pins are inputs).

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk.
- Values held during reset: duty_reg = 0, period_reg = 12'hFFF, counter = 0, pwm_out = 0.
- Data bus: data = {uio_in[3:0], ui_in[7:0]}.
- Register write, on a clk rising edge with wr_en = 1:
  - sel = 0 loads duty_reg <= data.
  - sel = 1 loads period_reg <= data.
  - The unselected register is unchanged.
  - wr_en = 0 leaves both registers unchanged.
- New register values take effect at the next compare. There is no shadowing or end-of-period synchronisation.
- Counter each cycle: if counter >= period_reg then counter <= 0, else counter <= counter + 1.
  - The period is period_reg + 1 cycles.
  - If period is lowered below the current count, the counter wraps to 0 on the next edge.
- pwm_out is registered: pwm_out <= (counter < duty_reg), using the pre-edge counter and register values.
- Output latency: pwm_out lags the counter by 1 cycle.
- Boundary behaviour:
  - duty_reg = 0: pwm_out is constantly 0.
  - duty_reg > period_reg: pwm_out is constantly 1 (100%).
  - period_reg = 0: counter stays at 0; output is 1 if duty_reg >= 1, else 0.
  - Simultaneous write and wrap: the write lands; the counter wraps using the old period this edge and the new one thereafter.
  - Reset mid-period returns all state to the reset values immediately, regardless of clk.
- Unused inputs (ena, uio_in[5:4]) have no effect.

Decomposition:
- Package samuelm_pwm_pkg holds:
  - PWM_W = 12.
  - SEL_DUTY = 1'b0, SEL_PERIOD = 1'b1.
  - Reset constants DUTY_RST = 12'h000, PERIOD_RST = 12'hFFF.
- Sub-module samuelm_pwm_core contains counter, compare and output flop. Inputs: clk, rst_n, duty, period. Output: pwm.
- The top contains pin unpacking, the two config registers, and output tie-offs.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles, then release with no writes -> pwm_out = 0 for 8192 cycles; uio_oe = 0, uio_out = 0, uo_out[7:1] = 0 throughout.
- Basic PWM: write period = 9 (sel = 1), then duty = 3 (sel = 0) -> pwm_out repeats 3 cycles high, 7 low (period 10 cycles), steady over 20 periods.
- Register isolation and full width:
  - Write period = 12'hABC; write duty = 12'h123 with sel = 0 -> period unaffected; high 0x123 cycles in a 0xABD-cycle period.
  - Verify data[11:8] is taken from uio_in[3:0].
- Extremes:
  - duty = 0 -> constant low.
  - duty = 10 with period = 9 -> constant high.
  - period = 0 with duty = 1 -> constant high.
- Live update: with period = 99 and counter near 80, write period = 20 -> counter wraps to 0 on the next edge; subsequent periods are 21 cycles.
- Reset mid-operation: assert rst_n asynchronously between clock edges while pwm_out = 1 -> pwm_out drops immediately; after release the registers read as reset values (constant low output).
